// File: rtl/rv32i_instr_encoder.sv
// Encodes decoded RV32I fields back into instruction words and queues them, with a per-word
// error flag, in a small FIFO that presents a valid/ready stream to the fetch side.
module rv32i_instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_fmt,
  input  logic [6:0]              req_opcode,
  input  logic [2:0]              req_funct3,
  input  logic [6:0]              req_funct7,
  input  logic [4:0]              req_rd,
  input  logic [4:0]              req_rs1,
  input  logic [4:0]              req_rs2,
  input  logic [31:0]             req_imm,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             instr,
  output logic                    instr_err,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    FmtR     = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtShift = 3'd6,
    FmtRsvd  = 3'd7
  } fmt_e;

  logic signed [31:0] imm_s;
  logic               imm12_bad;
  logic               immb_bad;
  logic               immj_bad;
  logic [31:0]        enc_word;
  logic               enc_err;

  assign imm_s     = $signed(req_imm);
  assign imm12_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
  assign immb_bad  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || req_imm[0];
  assign immj_bad  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || req_imm[0];

  // Illegal immediates still encode from the truncated bits; only the flag records the problem.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    unique case (fmt_e'(req_fmt))
      FmtR: enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FmtI: begin
        enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        enc_err  = imm12_bad;
      end
      FmtS: begin
        enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
        enc_err  = imm12_bad;
      end
      FmtB: begin
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], req_opcode};
        enc_err  = immb_bad;
      end
      FmtU: begin
        enc_word = {req_imm[31:12], req_rd, req_opcode};
        enc_err  = (req_imm[11:0] != 12'd0);
      end
      FmtJ: begin
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
        enc_err  = immj_bad;
      end
      FmtShift: begin
        enc_word = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, req_opcode};
        enc_err  = (req_imm[31:5] != 27'd0);
      end
      FmtRsvd: begin
        enc_word = '0;
        enc_err  = 1'b1;
      end
      default: begin
        enc_word = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [32:0]   head;
  logic          push;
  logic          pop;

  assign req_ready   = (count_q != CW'(DEPTH));
  assign instr_valid = (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign instr       = instr_valid ? head[31:0] : 32'd0;
  assign instr_err   = instr_valid ? head[32] : 1'b0;
  assign count       = count_q;

  // Flush wins over both handshakes in its cycle.
  assign push = req_valid && req_ready && !flush;
  assign pop  = instr_valid && instr_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {enc_err, enc_word};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed self-checking bench for rv32i_instr_encoder: encodings, error flags, FIFO full/drain,
// flush and asynchronous reset.
module tb_rv32i_instr_encoder;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_err;
  logic [2:0]  count;

  int checks;
  int errors;

  rv32i_instr_encoder #(.DEPTH(4)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fmt     (req_fmt),
    .req_opcode  (req_opcode),
    .req_funct3  (req_funct3),
    .req_funct7  (req_funct7),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_err   (instr_err),
    .count       (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    req_fmt    = fmt;
    req_opcode = op;
    req_funct3 = f3;
    req_funct7 = f7;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", instr_valid);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    checks++;
    if (instr !== 32'd0 || instr_err !== 1'b0) begin
      errors++; $display("FAIL reset_instr: got %h/%b want 0/0", instr, instr_err);
    end
  endtask

  task automatic test_addi();
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    req_valid   = 1'b1;
    instr_ready = 1'b0;
    step();
    req_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00500093 || instr_err !== 1'b0) begin
      errors++;
      $display("FAIL addi: got v=%b %h err=%b want v=1 00500093 err=0",
               instr_valid, instr, instr_err);
    end
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("FAIL addi_count: got %0d want 1", count);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL addi_pop: got count=%0d v=%b want 0/0", count, instr_valid);
    end
  endtask

  task automatic test_back_to_back();
    vecs[0]  = '{3'd3, 7'h63, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0};
    vecs[1]  = '{3'd4, 7'h37, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0};
    vecs[2]  = '{3'd5, 7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0};
    vecs[3]  = '{3'd0, 7'h33, 3'd0, 7'd0,  5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0};
    vecs[4]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0};
    vecs[5]  = '{3'd2, 7'h23, 3'd2, 7'd0,  5'd7, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0};
    vecs[6]  = '{3'd6, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3,        32'h4030D093, 1'b0};
    vecs[7]  = '{3'd1, 7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, 1'b1};
    vecs[8]  = '{3'd1, 7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0};
    vecs[9]  = '{3'd3, 7'h63, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'd7,        32'h00208363, 1'b1};
    vecs[10] = '{3'd7, 7'h13, 3'd1, 7'h20, 5'd1, 5'd1, 5'd1, 32'd5,        32'h00000000, 1'b1};
    vecs[11] = '{3'd6, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd32,       32'h4000D093, 1'b1};
    vecs[12] = '{3'd4, 7'h37, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h12345001, 32'h123452B7, 1'b1};
    vecs[13] = '{3'd3, 7'h63, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'd4094,     32'h7E208FE3, 1'b0};
    vecs[14] = '{3'd5, 7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFF00000, 32'h800000EF, 1'b0};
    instr_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_req(vecs[i].fmt, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1,
              vecs[i].rs2, vecs[i].imm);
      req_valid = 1'b1;
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== vecs[i].exp || instr_err !== vecs[i].err) begin
        errors++;
        $display("FAIL enc_vec%0d: got v=%b %h err=%b want v=1 %h err=%b",
                 i, instr_valid, instr, instr_err, vecs[i].exp, vecs[i].err);
      end
      checks++;
      if (count !== 3'd1) begin
        errors++; $display("FAIL enc_count%0d: got %0d want 1", i, count);
      end
    end
    req_valid = 1'b0;
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got count=%0d v=%b want 0/0", count, instr_valid);
    end
  endtask

  task automatic test_full_drain();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 32'h00000093 | (32'(i) << 20);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i));
      req_valid = 1'b1;
      step();
    end
    checks++;
    if (count !== 3'd4 || req_ready !== 1'b0) begin
      errors++; $display("FAIL full: got count=%0d ready=%b want 4/0", count, req_ready);
    end
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4);
    step();
    checks++;
    if (count !== 3'd4 || instr !== w[0]) begin
      errors++; $display("FAIL full_hold: got count=%0d %h want 4 %h", count, instr, w[0]);
    end
    instr_ready = 1'b1;
    step();
    checks++;
    if (count !== 3'd3 || instr !== w[1] || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain1: got count=%0d %h rdy=%b want 3 %h 1", count, instr, req_ready, w[1]);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (count !== 3'd3 || instr !== w[2]) begin
      errors++; $display("FAIL drain2: got count=%0d %h want 3 %h", count, instr, w[2]);
    end
    step();
    checks++;
    if (count !== 3'd2 || instr !== w[3]) begin
      errors++; $display("FAIL drain3: got count=%0d %h want 2 %h", count, instr, w[3]);
    end
    step();
    checks++;
    if (count !== 3'd1 || instr !== w[4]) begin
      errors++; $display("FAIL drain4: got count=%0d %h want 1 %h", count, instr, w[4]);
    end
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL drain_empty: got count=%0d v=%b %h want 0 0 0", count, instr_valid, instr);
    end
  endtask

  task automatic test_flush();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'(10 + i));
      req_valid = 1'b1;
      step();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL flush_pre: got count=%0d want 3", count);
    end
    flush = 1'b1;
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL flush: got count=%0d v=%b %h want 0 0 0", count, instr_valid, instr);
    end
    step();
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got count=%0d v=%b want 0/0", count, instr_valid);
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
      req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("FAIL rst_pre: got count=%0d want 2", count);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got count=%0d v=%b rdy=%b want 0 0 1", count, instr_valid,
               req_ready);
    end
    checks++;
    if (instr !== 32'd0 || instr_err !== 1'b0) begin
      errors++; $display("FAIL rst_async_instr: got %h/%b want 0/0", instr, instr_err);
    end
    #1;
    nRST = 1'b1;
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || instr !== 32'h00500093 || instr_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got count=%0d %h err=%b want 1 00500093 0", count, instr,
               instr_err);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    nRST        = 1'b0;
    flush       = 1'b0;
    req_valid   = 1'b0;
    instr_ready = 1'b0;
    set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    test_reset();
    #2;
    nRST = 1'b1;
    step();
    test_addi();
    test_back_to_back();
    test_full_drain();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
